mem_responder: RTL

Memory-side responder for the `mem_intf` read/write strobe protocol. It holds a DEPTH x WIDTH register array and answers the single-cycle `read`/`write` accesses issued by the test-side `write_mem`/`read_mem` tasks. It also keeps protocol-checking status for the bench: a collision flag, an uninitialised-read flag and saturating access counters. It connects to the `mem` modport of `mem_intf` plus a small status/control sideband.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the mem_intf read/write strobe protocol. It holds
// a DEPTH x WIDTH register array, answers single-cycle read/write strobes and
// keeps protocol-checking status: a collision flag, an uninitialised-read flag
// and two saturating access counters.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   read, write    : access strobes, sampled on the rising edge
//   addr, data_in  : word address and write data
//   data_out       : registered read data, held until the next accepted read
//   rd_valid       : one-cycle pulse, data_out was loaded on this edge
//   clr_status     : synchronous clear of flags and counters
//   err_collision  : sticky, read and write were high together
//   err_uninit     : sticky, a never-written location was read
//   wr_count       : accepted writes, saturating
//   rd_count       : accepted reads, saturating
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read,
  input  logic             write,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  input  logic             clr_status,
  output logic             err_collision,
  output logic             err_uninit,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  // Access type, decoded directly from {read, write}.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'b00,
    ACC_WRITE = 2'b01,
    ACC_READ  = 2'b10,
    ACC_COLL  = 2'b11
  } acc_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  acc_e             acc;
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [DEPTH-1:0] written;

  assign acc = acc_e'({read, write});

  // ---------------------------------------------------------------------------
  // Storage array and written bitmap
  // ---------------------------------------------------------------------------
  // NOTE: the array must read back as zero after reset, so it is built from
  // resettable flops rather than a RAM macro; a RAM cannot be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written <= '0;
    end else if (acc == ACC_WRITE) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of block ordering.
      mem[addr]     <= data_in;
      written[addr] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (acc == ACC_READ) begin
        data_out <= mem[addr];
        rd_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status: sticky flags and saturating counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_collision <= 1'b0;
      err_uninit    <= 1'b0;
      wr_count      <= '0;
      rd_count      <= '0;
    end else begin
      case (acc)
        ACC_WRITE: begin
          if (wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
        end
        ACC_READ: begin
          if (rd_count != CNT_MAX) rd_count <= rd_count + 1'b1;
          if (!written[addr])      err_uninit <= 1'b1;
        end
        ACC_COLL: begin
          err_collision <= 1'b1;
        end
        default: ;
      endcase
      // Placed last so the clear overrides any set or increment on this edge.
      if (clr_status) begin
        err_collision <= 1'b0;
        err_uninit    <= 1'b0;
        wr_count      <= '0;
        rd_count      <= '0;
      end
    end
  end

endmodule
